// File: rtl/joy_conditioner.sv
// Purpose : joystick/button conditioner for NUM_PLAYERS players: rotation, sync, debounce,
//           SOCD resolution, optional 4-way restriction and per-button autofire.
// Latency : 3 clk from an asynchronous input change to a registered output with debounce
//           bypassed; debounce adds DEBOUNCE_TICKS ce ticks of qualification plus 1 clk.
// Backpressure: none; all outputs are level signals refreshed every clk.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   ce                timebase enable for the debounce and autofire counters
//   dir_in/dir_out    per player p at [4p+3:4p] = {up,down,left,right}, active-high
//   btn_in/btn_out    player p buttons at [NUM_BTN*p +: NUM_BTN], active-high
//   rotate            1 = rotate directions for a horizontal monitor
//   socd_mode         0 last-wins, 1 neutral, 2 first-wins, 3 up-priority / last-wins horizontal
//   four_way          1 = suppress diagonals
//   autofire_en       per-button autofire enable, shared by all players
module joy_conditioner #(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_BTN        = 4,
    parameter int DEBOUNCE_TICKS = 0,
    parameter int AUTOFIRE_TICKS = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ce,
    input  logic [4*NUM_PLAYERS-1:0]       dir_in,
    input  logic [NUM_BTN*NUM_PLAYERS-1:0] btn_in,
    input  logic                           rotate,
    input  logic [1:0]                     socd_mode,
    input  logic                           four_way,
    input  logic [NUM_BTN-1:0]             autofire_en,
    output logic [4*NUM_PLAYERS-1:0]       dir_out,
    output logic [NUM_BTN*NUM_PLAYERS-1:0] btn_out
);

    localparam int ND   = 4 * NUM_PLAYERS;
    localparam int NBT  = NUM_BTN * NUM_PLAYERS;
    localparam int NB   = ND + NBT;
    localparam int AF_W = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS + 1) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_TICKS - 1);

    // ------------------------------------------------------------------
    // Rotation: up<-left, down<-right, left<-down, right<-up
    // ------------------------------------------------------------------
    logic [ND-1:0] dir_rot;

    always_comb begin
        dir_rot = dir_in;
        if (rotate) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                dir_rot[4*p +: 4] = {dir_in[4*p+1], dir_in[4*p], dir_in[4*p+2], dir_in[4*p+3]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser over every direction and button bit
    // ------------------------------------------------------------------
    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {btn_in, dir_rot};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit must disagree with its stable value for
    // DEBOUNCE_TICKS consecutive ce ticks before it is accepted.
    // ------------------------------------------------------------------
    logic [NB-1:0] stable;

    if (DEBOUNCE_TICKS == 0) begin : g_bypass
        assign stable = sync2_q;
    end else begin : g_debounce
        localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
        localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

        logic [NB-1:0]   db_stable_q, db_stable_d;
        logic [DB_W-1:0] db_cnt_q [NB];
        logic [DB_W-1:0] db_cnt_d [NB];

        always_comb begin
            db_stable_d = db_stable_q;
            for (int i = 0; i < NB; i++) begin
                db_cnt_d[i] = '0;
                if (sync2_q[i] != db_stable_q[i]) begin
                    db_cnt_d[i] = db_cnt_q[i];
                    if (ce) begin
                        if (db_cnt_q[i] == DB_LAST) begin
                            db_stable_d[i] = sync2_q[i];
                            db_cnt_d[i]    = '0;
                        end else begin
                            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_stable_q <= '0;
                for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
            end else begin
                db_stable_q <= db_stable_d;
                for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
            end
        end

        assign stable = db_stable_q;
    end

    // ------------------------------------------------------------------
    // Edge history, SOCD / 4-way state, autofire state, output registers
    // ------------------------------------------------------------------
    logic [NB-1:0]          stable_dly_q, stable_dly_d;
    logic [1:0]             last_v_q [NUM_PLAYERS];   // {up,down}
    logic [1:0]             last_v_d [NUM_PLAYERS];
    logic [1:0]             last_h_q [NUM_PLAYERS];   // {left,right}
    logic [1:0]             last_h_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] axis_v_q, axis_v_d;       // 1 = vertical was last
    logic [NBT-1:0]         af_q, af_d;
    logic [AF_W-1:0]        af_cnt_q [NBT];
    logic [AF_W-1:0]        af_cnt_d [NBT];
    logic [ND-1:0]          dir_out_q, dir_out_d;
    logic [NBT-1:0]         btn_out_q, btn_out_d;

    always_comb begin
        logic [3:0] s;
        logic [3:0] rise;
        logic [1:0] v_res;
        logic [1:0] h_res;
        logic       v_rise;
        logic       h_rise;
        logic       bs;
        logic       bsd;
        int         b;

        stable_dly_d = stable;
        axis_v_d     = axis_v_q;
        af_d         = af_q;
        dir_out_d    = '0;
        btn_out_d    = '0;
        s            = '0;
        rise         = '0;
        v_res        = '0;
        h_res        = '0;
        v_rise       = 1'b0;
        h_rise       = 1'b0;
        bs           = 1'b0;
        bsd          = 1'b0;
        b            = 0;

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            s    = stable[4*p +: 4];
            rise = s & ~stable_dly_q[4*p +: 4];

            // Most recent press per axis; a same-clk tie favours up / left.
            last_v_d[p] = last_v_q[p];
            if (rise[3])      last_v_d[p] = 2'b10;
            else if (rise[2]) last_v_d[p] = 2'b01;

            last_h_d[p] = last_h_q[p];
            if (rise[1])      last_h_d[p] = 2'b10;
            else if (rise[0]) last_h_d[p] = 2'b01;

            // Axis of the most recent press; simultaneous presses on both axes keep the old value.
            v_rise = |rise[3:2];
            h_rise = |rise[1:0];
            if (v_rise && !h_rise)      axis_v_d[p] = 1'b1;
            else if (h_rise && !v_rise) axis_v_d[p] = 1'b0;

            // Resolution uses the updated history so a new press wins on the same clk.
            v_res = s[3:2];
            if (s[3:2] == 2'b11) begin
                case (socd_mode)
                    2'd0:    v_res = last_v_d[p];
                    2'd1:    v_res = 2'b00;
                    2'd2:    v_res = {last_v_d[p][0], last_v_d[p][1]};
                    default: v_res = 2'b10;
                endcase
            end

            h_res = s[1:0];
            if (s[1:0] == 2'b11) begin
                case (socd_mode)
                    2'd1:    h_res = 2'b00;
                    2'd2:    h_res = {last_h_d[p][0], last_h_d[p][1]};
                    default: h_res = last_h_d[p];
                endcase
            end

            if (four_way && (|v_res) && (|h_res)) begin
                dir_out_d[4*p +: 4] = axis_v_d[p] ? {v_res, 2'b00} : {2'b00, h_res};
            end else begin
                dir_out_d[4*p +: 4] = {v_res, h_res};
            end

            for (int j = 0; j < NUM_BTN; j++) begin
                b   = p * NUM_BTN + j;
                bs  = stable[ND + b];
                bsd = stable_dly_q[ND + b];

                // Autofire runs whenever the button is held so enabling it mid-press
                // shows the current phase on the next clk.
                af_cnt_d[b] = '0;
                if (!bs) begin
                    af_d[b] = 1'b0;
                end else if (!bsd) begin
                    af_d[b] = 1'b1;
                end else begin
                    af_cnt_d[b] = af_cnt_q[b];
                    if (ce) begin
                        if (af_cnt_q[b] == AF_LAST) begin
                            af_d[b]     = ~af_q[b];
                            af_cnt_d[b] = '0;
                        end else begin
                            af_cnt_d[b] = af_cnt_q[b] + AF_W'(1);
                        end
                    end
                end

                btn_out_d[b] = autofire_en[j] ? af_d[b] : bs;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_dly_q <= '0;
            axis_v_q     <= '1;
            af_q         <= '0;
            dir_out_q    <= '0;
            btn_out_q    <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                last_v_q[p] <= '0;
                last_h_q[p] <= '0;
            end
            for (int b = 0; b < NBT; b++) af_cnt_q[b] <= '0;
        end else begin
            stable_dly_q <= stable_dly_d;
            axis_v_q     <= axis_v_d;
            af_q         <= af_d;
            dir_out_q    <= dir_out_d;
            btn_out_q    <= btn_out_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                last_v_q[p] <= last_v_d[p];
                last_h_q[p] <= last_h_d[p];
            end
            for (int b = 0; b < NBT; b++) af_cnt_q[b] <= af_cnt_d[b];
        end
    end

    assign dir_out = dir_out_q;
    assign btn_out = btn_out_q;

endmodule

// File: tb/tb_joy_conditioner.sv
// Purpose : scoreboard bench for joy_conditioner; one instance with debounce bypassed and
//           one with DEBOUNCE_TICKS=3, both with AUTOFIRE_TICKS=2, sharing all inputs.
// Latency : expectations are queued with the cycle at which they must hold.
// Backpressure: none; the monitor samples outputs on every falling clock edge.
module tb_joy_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce = 1'b1;
    logic [7:0] dir_in;
    logic [7:0] btn_in;
    logic       rotate;
    logic [1:0] socd_mode;
    logic       four_way;
    logic [3:0] autofire_en;
    logic [7:0] dir_out, btn_out, db_dir_out, db_btn_out;

    always #5 clk = ~clk;

    joy_conditioner #(
        .NUM_PLAYERS(2), .NUM_BTN(4), .DEBOUNCE_TICKS(0), .AUTOFIRE_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .dir_in(dir_in), .btn_in(btn_in),
        .rotate(rotate), .socd_mode(socd_mode), .four_way(four_way),
        .autofire_en(autofire_en), .dir_out(dir_out), .btn_out(btn_out)
    );

    joy_conditioner #(
        .NUM_PLAYERS(2), .NUM_BTN(4), .DEBOUNCE_TICKS(3), .AUTOFIRE_TICKS(2)
    ) dut_db (
        .clk(clk), .reset_n(reset_n), .ce(ce), .dir_in(dir_in), .btn_in(btn_in),
        .rotate(rotate), .socd_mode(socd_mode), .four_way(four_way),
        .autofire_en(autofire_en), .dir_out(db_dir_out), .btn_out(db_btn_out)
    );

    typedef struct {
        int         cyc;
        int         sel;   // 0 dir_out, 1 btn_out, 2 db btn_out, 3 db dir_out
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   ce_div = 1'b0;

    // cyc = number of rising edges seen; ce is refreshed just after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1 ce = ce_div ? ((cyc % 4) == 0) : 1'b1;
    end

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].sel)
                    0:       act = dir_out;
                    1:       act = btn_out;
                    2:       act = db_btn_out;
                    default: act = db_dir_out;
                endcase
                n_run = n_run + 1;
                if ((act & sb[i].mask) !== sb[i].exp) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %h, expected %h (cycle %0d)",
                             sb[i].name, act & sb[i].mask, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input int sel, input logic [7:0] mask,
                             input logic [7:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc + d;
        e.sel  = sel;
        e.mask = mask;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        reset_n     = 1'b0;
        dir_in      = '0;
        btn_in      = '0;
        rotate      = 1'b0;
        socd_mode   = 2'd0;
        four_way    = 1'b0;
        autofire_en = '0;

        tick(2);
        expect_at(0, 0, 8'hFF, 8'h00, "reset_dir");
        expect_at(0, 1, 8'hFF, 8'h00, "reset_btn");
        expect_at(0, 2, 8'hFF, 8'h00, "reset_db_btn");
        tick(1);
        reset_n = 1'b1;
        tick(4);

        // Last-wins on player 0
        dir_in = 8'h01;
        expect_at(2, 0, 8'hFF, 8'h00, "lw_latency_pre");
        expect_at(3, 0, 8'hFF, 8'h01, "lw_right");
        tick(5);
        dir_in = 8'h03;
        expect_at(2, 0, 8'hFF, 8'h01, "lw_pre_left");
        expect_at(3, 0, 8'hFF, 8'h02, "lw_left_wins");
        tick(5);
        dir_in = 8'h01;
        expect_at(3, 0, 8'hFF, 8'h01, "lw_release_left");
        tick(5);
        dir_in = 8'h00;
        expect_at(3, 0, 8'hFF, 8'h00, "lw_idle");
        tick(5);

        // Neutral, then first-wins, then up-priority
        socd_mode = 2'd1;
        dir_in    = 8'h08;
        expect_at(3, 0, 8'hFF, 8'h08, "up_alone");
        tick(5);
        dir_in = 8'h0C;
        expect_at(3, 0, 8'hFF, 8'h00, "neutral");
        tick(5);
        socd_mode = 2'd2;
        expect_at(1, 0, 8'hFF, 8'h08, "first_wins_up");
        tick(3);
        dir_in = 8'h00;
        tick(5);
        dir_in = 8'h04;
        tick(5);
        dir_in = 8'h0C;
        expect_at(3, 0, 8'hFF, 8'h04, "first_wins_down");
        tick(5);
        socd_mode = 2'd3;
        expect_at(0, 0, 8'hFF, 8'h04, "mode3_pre");
        expect_at(1, 0, 8'hFF, 8'h08, "up_priority");
        tick(3);
        dir_in    = 8'h00;
        socd_mode = 2'd0;
        tick(5);

        // Four-way restriction
        four_way = 1'b1;
        dir_in   = 8'h08;
        expect_at(3, 0, 8'hFF, 8'h08, "fw_up");
        tick(5);
        dir_in = 8'h09;
        expect_at(3, 0, 8'hFF, 8'h01, "fw_horizontal");
        tick(5);
        dir_in = 8'h08;
        expect_at(2, 0, 8'hFF, 8'h01, "fw_hold");
        expect_at(3, 0, 8'hFF, 8'h08, "fw_back_up");
        tick(5);
        dir_in   = 8'h00;
        four_way = 1'b0;
        tick(5);

        // Autofire on P0 btn0, plain button on P1 btn1
        autofire_en = 4'b0001;
        btn_in      = 8'h21;
        expect_at(2, 1, 8'hFF, 8'h00, "af_pre");
        for (int i = 0; i < 10; i++) begin
            expect_at(3 + i, 1, 8'hFF, (((i / 2) % 2) == 0) ? 8'h21 : 8'h20,
                      $sformatf("af_pattern_%0d", i));
        end
        tick(10);
        btn_in = 8'h00;
        expect_at(3, 1, 8'hFF, 8'h00, "af_release");
        tick(5);
        autofire_en = 4'b0000;

        // Debounce: ce every 4 clks, press issued on a cycle with cyc%4==1
        ce_div = 1'b1;
        tick(4);
        while ((cyc % 4) != 1) tick(1);
        expect_at(0, 2, 8'hFF, 8'h00, "db_idle");
        btn_in = 8'h01;
        expect_at(5, 2, 8'hFF, 8'h00, "db_glitch_a");
        expect_at(10, 2, 8'hFF, 8'h00, "db_glitch_b");
        expect_at(13, 2, 8'hFF, 8'h00, "db_glitch_c");
        expect_at(16, 2, 8'hFF, 8'h00, "db_glitch_d");
        tick(8);
        btn_in = 8'h00;
        tick(12);
        btn_in = 8'h01;
        expect_at(12, 2, 8'hFF, 8'h00, "db_press_pre");
        expect_at(13, 2, 8'hFF, 8'h01, "db_press_accept");
        tick(20);
        btn_in = 8'h00;
        expect_at(12, 2, 8'hFF, 8'h01, "db_release_pre");
        expect_at(13, 2, 8'hFF, 8'h00, "db_release");
        tick(16);
        ce_div = 1'b0;
        tick(2);

        // Rotation on P1, then reset mid-press
        rotate = 1'b1;
        dir_in = 8'h20;
        expect_at(3, 0, 8'hFF, 8'h80, "rot_p1_up");
        tick(5);
        reset_n = 1'b0;
        expect_at(0, 0, 8'hFF, 8'h00, "reset_async_dir");
        expect_at(0, 1, 8'hFF, 8'h00, "reset_async_btn");
        tick(2);
        reset_n = 1'b1;
        expect_at(2, 0, 8'hFF, 8'h00, "reset_release_pre");
        expect_at(3, 0, 8'hFF, 8'h80, "reset_release_out");
        tick(5);

        for (int t = 0; t < 100 && sb.size() > 0; t++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations never checked, required 0", sb.size());
            n_run  = n_run + sb.size();
            n_fail = n_fail + sb.size();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/joy_conditioner.md
Name: joy_conditioner

Overview:
- Parametrised successor to the existing single-player 8-way SOCD resolver.
- Conditions digital joystick and button inputs for NUM_PLAYERS players in one block:
  - orientation rotation
  - input synchronisation and per-bit debounce
  - selectable simultaneous-opposite-direction (SOCD) policy
  - optional 4-way restriction
  - per-button autofire
- Sits between the keyboard/gamepad merge logic in the top-level wrapper and the game core input ports; outputs are active-high and registered.

Parameters:
- NUM_PLAYERS, 2, number of independent player channels.
- NUM_BTN, 4, buttons per player.
- DEBOUNCE_TICKS, 0, consecutive ce ticks a bit must differ from its stable value before it is accepted; 0 = bypass.
- AUTOFIRE_TICKS, 8, ce ticks per autofire half-period; must be ≥1.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ce, in, 1, timebase enable for debounce and autofire counters.
- dir_in, in, 4*NUM_PLAYERS, per player p at [4p+3:4p] = {up,down,left,right}, active-high, asynchronous.
- btn_in, in, NUM_BTN*NUM_PLAYERS, player p buttons at [NUM_BTN*p +: NUM_BTN], active-high, asynchronous.
- rotate, in, 1, 1 = rotate directions for horizontal monitor.
- socd_mode, in, 2, 0 last-wins, 1 neutral, 2 first-wins, 3 up-priority vertical / last-wins horizontal.
- four_way, in, 1, 1 = suppress diagonals.
- autofire_en, in, NUM_BTN, per-button autofire enable (shared by all players).
- dir_out, out, 4*NUM_PLAYERS, conditioned directions, same bit layout as dir_in.
- btn_out, out, NUM_BTN*NUM_PLAYERS, conditioned buttons.

Behaviour:
- Reset (reset_n low, async):
  - all flops clear: dir_out=0, btn_out=0.
  - last_h=00, last_v=00, axis_last=V.
  - all counters 0.
- Rotation (combinational, before sync). With rotate=1: up←left, down←right, left←down, right←up. Changing rotate mid-press is treated as ordinary input changes.
- Sync: 2-flop synchroniser per bit.
- Debounce (DEBOUNCE_TICKS>0):
  - per-bit counter increments on ce while sync2≠stable, and clears whenever sync2==stable.
  - when the counter reaches DEBOUNCE_TICKS on a ce tick, stable takes sync2 and the counter clears.
  - bypass mode: stable<=sync2 every clk.
- Edge detect: new = stable & ~stable_d (stable_d = 1-clk delayed stable).
  - vertical: new up → last_v=up; new down → last_v=down; same-clk tie → up.
  - horizontal: new left → last_h=left; new right → last_h=right; same-clk tie → left.
- SOCD, applied only when both bits of an axis are stable-high:
  - mode 0: last_v / last_h.
  - mode 1: neither direction.
  - mode 2: the direction opposite last_v / last_h.
  - mode 3: vertical → up; horizontal → last-wins.
  - with one or neither bit high, stable passes through.
- Four-way (four_way=1):
  - axis_last=V on any vertical rising edge, =H on any horizontal rising edge; same-clk tie keeps the previous value.
  - if resolved output has both a vertical and a horizontal bit, only the axis_last axis is output.
  - when that axis releases, the other axis appears on the next clk.
- Autofire, per player-button:
  - autofire_en=0: btn_out = stable.
  - autofire_en=1: on the stable rising edge, output 1 and counter=0. While held, the counter counts ce ticks; at AUTOFIRE_TICKS the output toggles and the counter clears.
  - release → output 0 next clk, counter 0.
  - toggling autofire_en while held takes effect next clk.
- Latency, bypass debounce: async input change → dir_out/btn_out changes 3 clks later (sync1, sync2/stable, output reg). Debounce adds the DEBOUNCE_TICKS ce-tick qualification.
- Channel independence: players share only the mode inputs, ce and autofire_en.
- Mode changes while held: SOCD mode change applies on the next clk using the current last_*/axis_last state; no state is flushed.

Test Plan:
- Last-wins, P0, mode 0, bypass: right held, then left added → dir_out[1:0]=10 after 3 clks. Release left → 01 after 3 clks.
- Neutral and first-wins: up then down held. Mode 1 → [3:2]=00. Switch to mode 2 → 10 (up) next clk. Switch to mode 3 with down-first → 10.
- Four-way: up held, right added → dir_out[3:0]=0001. Release right → 1000 one clk after stable release.
- Debounce, DEBOUNCE_TICKS=3, ce every 4 clks: 2-tick fire glitch → btn_out stays 0. 5-tick press → btn_out=1 after the third ce tick plus 1 clk.
- Autofire, AUTOFIRE_TICKS=2, ce every clk, btn0 held 10 clks → btn_out pattern 1,1,0,0,1,1,0,0,… starting 3 clks after the press. Release → 0.
- Rotation plus reset: rotate=1, dir_in left on P1 → dir_out[7:4]=1000. Assert reset_n low mid-press → all outputs 0 immediately. After release of reset, the output returns 3 clks later.
